// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, data/strobe widths and the
// simple-to-AXI4-Lite master state encoding.
package axi4lite_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned RESP_WIDTH = 2;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESPOND = 3'd5
    } master_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } wr_payload_t;

    typedef struct packed {
        logic                  write;
        logic [RESP_WIDTH-1:0] resp;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_payload_t;

endpackage

// File: rtl/simple_to_axi4lite_master.sv
// Bridges a single-outstanding valid/ready command port onto an AXI4-Lite
// master interface and returns data plus the AXI response code.
module simple_to_axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [RESP_WIDTH-1:0] rsp_resp,
    output logic                  rsp_write,

    output logic [ADDR_WIDTH-1:0] AXI_AWADDR,
    output logic                  AXI_AWVALID,
    input  logic                  AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] AXI_WDATA,
    output logic [STRB_WIDTH-1:0] AXI_WSTRB,
    output logic                  AXI_WVALID,
    input  logic                  AXI_WREADY,
    input  logic [RESP_WIDTH-1:0] AXI_BRESP,
    input  logic                  AXI_BVALID,
    output logic                  AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] AXI_ARADDR,
    output logic                  AXI_ARVALID,
    input  logic                  AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] AXI_RDATA,
    input  logic [RESP_WIDTH-1:0] AXI_RRESP,
    input  logic                  AXI_RVALID,
    output logic                  AXI_RREADY
);

    master_state_e          r_state, w_state_nxt;
    logic                   r_cmd_ready, w_cmd_ready;
    logic                   r_awvalid, w_awvalid;
    logic                   r_wvalid, w_wvalid;
    logic                   r_bready, w_bready;
    logic                   r_arvalid, w_arvalid;
    logic                   r_rready, w_rready;
    logic                   r_rsp_valid, w_rsp_valid;
    logic                   r_aw_done, w_aw_done;
    logic                   r_w_done, w_w_done;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr;
    wr_payload_t            r_wr, w_wr;
    rsp_payload_t           r_rsp, w_rsp;
    logic                   w_misaligned;

    assign w_misaligned = (CHECK_ALIGN != 0) && (cmd_address[1:0] != 2'b00);

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_rsp_valid = 1'b0;
        w_aw_done   = r_aw_done;
        w_w_done    = r_w_done;
        w_addr      = r_addr;
        w_wr        = r_wr;
        w_rsp       = r_rsp;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_addr     = cmd_address;
                    w_wr.wdata = cmd_wdata;
                    w_wr.wstrb = cmd_wstrb;
                    w_aw_done  = 1'b0;
                    w_w_done   = 1'b0;
                    if (w_misaligned) begin
                        w_rsp.write = cmd_write;
                        w_rsp.resp  = RESP_SLVERR;
                        w_rsp.rdata = '0;
                        w_rsp_valid = 1'b1;
                        w_state_nxt = ST_RESPOND;
                    end else if (cmd_write) begin
                        w_awvalid   = 1'b1;
                        w_wvalid    = 1'b1;
                        w_state_nxt = ST_WR_REQ;
                    end else begin
                        w_arvalid   = 1'b1;
                        w_state_nxt = ST_RD_REQ;
                    end
                end else begin
                    w_cmd_ready = 1'b1;
                end
            end

            // AW and W complete independently; each VALID drops after its own handshake.
            ST_WR_REQ: begin
                w_aw_done = r_aw_done | (r_awvalid & AXI_AWREADY);
                w_w_done  = r_w_done  | (r_wvalid  & AXI_WREADY);
                w_awvalid = ~w_aw_done;
                w_wvalid  = ~w_w_done;
                if (w_aw_done && w_w_done) begin
                    w_bready    = 1'b1;
                    w_state_nxt = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (AXI_BVALID && r_bready) begin
                    w_rsp.write = 1'b1;
                    w_rsp.resp  = AXI_BRESP;
                    w_rsp.rdata = '0;
                    w_rsp_valid = 1'b1;
                    w_state_nxt = ST_RESPOND;
                end else begin
                    w_bready = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (r_arvalid && AXI_ARREADY) begin
                    w_rready    = 1'b1;
                    w_state_nxt = ST_RD_RESP;
                end else begin
                    w_arvalid = 1'b1;
                end
            end

            ST_RD_RESP: begin
                if (AXI_RVALID && r_rready) begin
                    w_rsp.write = 1'b0;
                    w_rsp.resp  = AXI_RRESP;
                    w_rsp.rdata = AXI_RDATA;
                    w_rsp_valid = 1'b1;
                    w_state_nxt = ST_RESPOND;
                end else begin
                    w_rready = 1'b1;
                end
            end

            ST_RESPOND: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_cmd_ready = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rsp_valid = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wr        <= '0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_rsp_valid <= w_rsp_valid;
            r_aw_done   <= w_aw_done;
            r_w_done    <= w_w_done;
            r_addr      <= w_addr;
            r_wr        <= w_wr;
            r_rsp       <= w_rsp;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_resp    = r_rsp.resp;
    assign rsp_write   = r_rsp.write;
    assign AXI_AWADDR  = r_addr;
    assign AXI_AWVALID = r_awvalid;
    assign AXI_WDATA   = r_wr.wdata;
    assign AXI_WSTRB   = r_wr.wstrb;
    assign AXI_WVALID  = r_wvalid;
    assign AXI_BREADY  = r_bready;
    assign AXI_ARADDR  = r_addr;
    assign AXI_ARVALID = r_arvalid;
    assign AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_simple_to_axi4lite_master.sv
// Bench for simple_to_axi4lite_master: transaction-level model, configurable
// AXI slave with wait states, directed scenarios then randomized traffic.
module tb_simple_to_axi4lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
    logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
    logic [3:0]  AXI_WSTRB;
    logic [1:0]  AXI_BRESP, AXI_RRESP;
    logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

    always #5 clk = ~clk;

    simple_to_axi4lite_master #(.ADDR_WIDTH(32), .CHECK_ALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
    );

    int unsigned n_cmp = 0, n_bad = 0, cyc = 0;

    // transaction model
    bit          busy, m_write, m_mis, aw_done, w_done, ar_done, b_done, r_done, rsp_pending;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        e_write;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;

    // slave knobs and wait counters
    int unsigned aw_d, w_d, ar_d, b_d, r_d, rsp_lo;
    int unsigned aw_c, w_c, ar_c, b_c, r_c;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    bit          spur_en;

    // per-transaction observations
    bit          acc_seen;
    int unsigned n_rsp;
    int          t_acc, t_aw_hs, t_w_hs, t_bready, t_rsp;
    int          n_awv, n_wv, n_arv, n_rspv, n_axiv;
    logic [31:0] o_awaddr, o_wdata, o_rdata;
    logic [1:0]  o_resp;
    logic        o_write;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; rsp_pending = 0; m_write = 0; m_mis = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    endtask

    task automatic knobs(input int unsigned awd, wd, ard, bd, rd,
                         input logic [1:0] br, input logic [31:0] rdat, input logic [1:0] rr,
                         input int unsigned lo);
        aw_d = awd; w_d = wd; ar_d = ard; b_d = bd; r_d = rd;
        s_bresp = br; s_rdata = rdat; s_rresp = rr; rsp_lo = lo;
    endtask

    // One clock: settle handshakes into the model, compare, then drive the slave side.
    task automatic step();
        bit          h_acc, h_aw, h_w, h_ar, h_b, h_r, h_rsp, wr_ok, rd_ok;
        logic [31:0] pa, pd, p_awaddr, p_wdata, p_rdata, p_rsp_rdata;
        logic [3:0]  ps;
        logic        pwr, p_rsp_write;
        logic [1:0]  p_bresp, p_rresp, p_rsp_resp;
        logic [6:0]  e_ctrl;
        h_acc = cmd_valid && cmd_ready;
        h_aw  = AXI_AWVALID && AXI_AWREADY;
        h_w   = AXI_WVALID && AXI_WREADY;
        h_ar  = AXI_ARVALID && AXI_ARREADY;
        h_b   = AXI_BVALID && AXI_BREADY;
        h_r   = AXI_RVALID && AXI_RREADY;
        h_rsp = rsp_valid && rsp_ready;
        pa = cmd_address; pd = cmd_wdata; ps = cmd_wstrb; pwr = cmd_write;
        p_awaddr = AXI_AWADDR; p_wdata = AXI_WDATA; p_bresp = AXI_BRESP;
        p_rdata = AXI_RDATA; p_rresp = AXI_RRESP;
        p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp; p_rsp_write = rsp_write;
        @(posedge clk);
        #1;
        cyc++;
        if (h_acc) begin
            busy = 1; m_write = pwr; m_addr = pa; m_wdata = pd; m_wstrb = ps;
            m_mis = (pa[1:0] != 2'b00);
            aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
            aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            rsp_pending = m_mis;
            if (m_mis) begin e_write = pwr; e_resp = 2'b10; e_rdata = 32'h0; end
            acc_seen = 1; t_acc = int'(cyc) - 1;
        end
        if (h_aw) begin aw_done = 1; t_aw_hs = int'(cyc) - 1; o_awaddr = p_awaddr; end
        if (h_w)  begin w_done = 1; t_w_hs = int'(cyc) - 1; o_wdata = p_wdata; end
        if (h_ar) ar_done = 1;
        if (h_b)  begin b_done = 1; rsp_pending = 1; e_write = 1; e_resp = p_bresp; e_rdata = 32'h0; end
        if (h_r)  begin r_done = 1; rsp_pending = 1; e_write = 0; e_resp = p_rresp; e_rdata = p_rdata; end
        if (h_rsp) begin
            busy = 0; rsp_pending = 0; n_rsp++;
            o_rdata = p_rsp_rdata; o_resp = p_rsp_resp; o_write = p_rsp_write;
        end

        wr_ok  = busy && m_write && !m_mis;
        rd_ok  = busy && !m_write && !m_mis;
        e_ctrl = {!busy, wr_ok && !aw_done, wr_ok && !w_done, wr_ok && aw_done && w_done && !b_done,
                  rd_ok && !ar_done, rd_ok && ar_done && !r_done, rsp_pending};
        chk("ctrl{cmd_ready,awv,wv,bready,arv,rready,rsp_valid}",
            {cmd_ready, AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY, rsp_valid}, e_ctrl);
        if (e_ctrl[5]) chk("awaddr", AXI_AWADDR, m_addr);
        if (e_ctrl[4]) chk("wdata_wstrb", {AXI_WDATA, AXI_WSTRB}, {m_wdata, m_wstrb});
        if (e_ctrl[2]) chk("araddr", AXI_ARADDR, m_addr);
        if (e_ctrl[0]) chk("rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {e_write, e_resp, e_rdata});

        if (busy) begin
            n_awv += int'(AXI_AWVALID); n_wv += int'(AXI_WVALID); n_arv += int'(AXI_ARVALID);
            if (AXI_AWVALID || AXI_WVALID || AXI_ARVALID) n_axiv++;
        end
        if (rsp_valid) begin n_rspv++; if (t_rsp < 0) t_rsp = int'(cyc); end
        if (AXI_BREADY && t_bready < 0) t_bready = int'(cyc);

        AXI_AWREADY = AXI_AWVALID && (aw_c >= aw_d);
        if (AXI_AWVALID) aw_c++;
        AXI_WREADY = AXI_WVALID && (w_c >= w_d);
        if (AXI_WVALID) w_c++;
        AXI_ARREADY = AXI_ARVALID && (ar_c >= ar_d);
        if (AXI_ARVALID) ar_c++;
        if (wr_ok && aw_done && w_done && !b_done) begin
            AXI_BVALID = (b_c >= b_d); AXI_BRESP = s_bresp; b_c++;
        end else begin
            AXI_BVALID = spur_en && ($urandom_range(3) == 0); AXI_BRESP = 2'($urandom);
        end
        if (rd_ok && ar_done && !r_done) begin
            AXI_RVALID = (r_c >= r_d); AXI_RDATA = s_rdata; AXI_RRESP = s_rresp; r_c++;
        end else begin
            AXI_RVALID = spur_en && ($urandom_range(3) == 0);
            AXI_RDATA = $urandom; AXI_RRESP = 2'($urandom);
        end
        if (rsp_valid && rsp_lo > 0) begin
            rsp_ready = 1'b0; rsp_lo--;
        end else begin
            rsp_ready = 1'b1;
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned n0, k;
        acc_seen = 0; n0 = n_rsp;
        t_acc = -1; t_aw_hs = -1; t_w_hs = -1; t_bready = -1; t_rsp = -1;
        n_awv = 0; n_wv = 0; n_arv = 0; n_rspv = 0; n_axiv = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        while (!acc_seen && k < 50) begin step(); k++; end
        chk("cmd_accepted", 128'(acc_seen), 128'(1));
        cmd_valid = 1'b0; cmd_address = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        k = 0;
        while (n_rsp == n0 && k < 300) begin step(); k++; end
        chk("rsp_returned", 128'(n_rsp - n0), 128'(1));
    endtask

    initial begin
        logic [31:0] a;
        int unsigned k;
        cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0;
        AXI_BVALID = 0; AXI_BRESP = 0; AXI_RVALID = 0; AXI_RDATA = 0; AXI_RRESP = 0;
        spur_en = 0; n_rsp = 0;
        model_reset();
        knobs(0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);

        #12;
        chk("reset_ctrl", {cmd_ready, AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY,
                           rsp_valid, rsp_resp, rsp_write}, 128'h0);
        chk("reset_data", {AXI_AWADDR, AXI_ARADDR, AXI_WDATA, rsp_rdata}, 128'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // zero-wait write, OKAY
        knobs(0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
        do_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        chk("t1_aw_hs_latency", 128'(t_aw_hs - t_acc), 128'(1));
        chk("t1_bready_latency", 128'(t_bready - t_acc), 128'(2));
        chk("t1_rsp_latency", 128'(t_rsp - t_acc), 128'(3));
        chk("t1_awaddr", o_awaddr, 32'h0000_0010);
        chk("t1_wdata", o_wdata, 32'hDEAD_BEEF);
        chk("t1_rsp", {o_write, o_resp, o_rdata}, {1'b1, 2'b00, 32'h0});

        // AWREADY delayed three cycles, WREADY immediate
        knobs(3, 0, 0, 0, 0, 2'b01, 32'h0, 2'b00, 0);
        do_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'h3);
        chk("t2_wvalid_cycles", 128'(n_wv), 128'(1));
        chk("t2_awvalid_cycles", 128'(n_awv), 128'(4));
        chk("t2_w_hs", 128'(t_w_hs - t_acc), 128'(1));
        chk("t2_aw_hs", 128'(t_aw_hs - t_acc), 128'(4));
        chk("t2_bready_latency", 128'(t_bready - t_acc), 128'(5));
        chk("t2_rsp", {o_write, o_resp}, {1'b1, 2'b01});

        // read with two R wait cycles
        knobs(0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 2'b00, 0);
        do_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        chk("t3_arvalid_cycles", 128'(n_arv), 128'(1));
        chk("t3_rsp_latency", 128'(t_rsp - t_acc), 128'(5));
        chk("t3_rsp", {o_write, o_resp, o_rdata}, {1'b0, 2'b00, 32'h1234_5678});

        // DECERR read with response back-pressured for five cycles
        knobs(0, 0, 0, 0, 0, 2'b00, 32'hCAFE_0008, 2'b11, 5);
        do_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        chk("t4_rsp_valid_cycles", 128'(n_rspv), 128'(6));
        chk("t4_rsp", {o_write, o_resp, o_rdata}, {1'b0, 2'b11, 32'hCAFE_0008});
        step();
        chk("t4_idle_after", 128'(cmd_ready), 128'(1));

        // misaligned write rejected locally
        knobs(0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
        do_cmd(1'b1, 32'h0000_0002, 32'h0000_0055, 4'hF);
        chk("t5_no_axi_valid", 128'(n_axiv), 128'(0));
        chk("t5_rsp_latency", 128'(t_rsp - t_acc), 128'(1));
        chk("t5_rsp", {o_write, o_resp, o_rdata}, {1'b1, 2'b10, 32'h0});

        // randomized traffic
        spur_en = 1;
        for (int i = 0; i < 200; i++) begin
            knobs($urandom_range(4), $urandom_range(4), $urandom_range(4), $urandom_range(4),
                  $urandom_range(4), 2'($urandom), $urandom, 2'($urandom), $urandom_range(3));
            a = $urandom;
            if ($urandom_range(4) != 0) a[1:0] = 2'b00;
            do_cmd(1'($urandom), a, $urandom, 4'($urandom));
            k = $urandom_range(2);
            for (int j = 0; j < int'(k); j++) step();
        end

        // asynchronous reset in the middle of a stalled write request
        spur_en = 0;
        knobs(60, 60, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
        acc_seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'h0000_0040; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        k = 0;
        while (!acc_seen && k < 50) begin step(); k++; end
        cmd_valid = 1'b0;
        step(); step();
        chk("t6_awvalid_before", {AXI_AWVALID, AXI_WVALID}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {AXI_AWVALID, AXI_WVALID, rsp_valid, cmd_ready, AXI_AWADDR}, 128'h0);
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_RVALID = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_ready_after_release", 128'(cmd_ready), 128'(1));
        knobs(0, 0, 1, 0, 1, 2'b00, 32'h0BAD_F00D, 2'b00, 0);
        do_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        chk("t6_recovery_read", {o_write, o_resp, o_rdata}, {1'b0, 2'b00, 32'h0BAD_F00D});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simple_to_axi4lite_master.md
Name: simple_to_axi4lite_master

Overview:
- Initiator-side counterpart of the AXI4-Lite-to-simple slave converter.
- Accepts single read/write commands on a simple valid/ready command port and issues them as AXI4-Lite master transactions.
- Returns read data plus the 2-bit AXI response on a simple response port.
- Used by internal controllers (DMA, debug) to reach AXI4-Lite peripherals. One outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, width of cmd_address and AXI_AWADDR/AXI_ARADDR.
- CHECK_ALIGN, 1, if 1 a command whose address[1:0]!=0 is rejected locally with SLVERR (2'b10) and no AXI traffic.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_address  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  32  write data.
- cmd_wstrb  input  4  write byte enables.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_resp  output  2  AXI response code (RRESP/BRESP or local 2'b10).
- rsp_write  output  1  response belongs to a write.
- AXI_AWADDR output ADDR_WIDTH; AXI_AWVALID output 1; AXI_AWREADY input 1.
- AXI_WDATA output 32; AXI_WSTRB output 4; AXI_WVALID output 1; AXI_WREADY input 1.
- AXI_BRESP input 2; AXI_BVALID input 1; AXI_BREADY output 1.
- AXI_ARADDR output ADDR_WIDTH; AXI_ARVALID output 1; AXI_ARREADY input 1.
- AXI_RDATA input 32; AXI_RRESP input 2; AXI_RVALID input 1; AXI_RREADY output 1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0 all outputs are 0: cmd_ready, all AXI VALID/READY, rsp_valid, rsp_rdata, rsp_resp, rsp_write, and address/data registers. State=IDLE.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESPOND.
- IDLE: cmd_ready=1. On accept, cmd_ready drops the next cycle and the command fields are captured.
  - write -> WR_REQ; AXI_AWVALID=AXI_WVALID=1 from the next cycle.
  - read -> RD_REQ; AXI_ARVALID=1 from the next cycle.
  - CHECK_ALIGN && misaligned -> RESPOND with rsp_resp=2'b10, rsp_rdata=0, and no AXI VALID ever asserted.
- WR_REQ:
  - AW and W handshakes are tracked independently (aw_done, w_done).
  - Each VALID deasserts the cycle after its own handshake and never drops before it.
  - Address and data stay stable while VALID is high.
  - Both handshakes may complete in the same or different cycles, in either order.
  - When both are done -> WR_RESP, AXI_BREADY=1.
- WR_RESP: on AXI_BVALID&&AXI_BREADY, capture AXI_BRESP, set rsp_write=1, deassert BREADY -> RESPOND.
- RD_REQ: on AXI_ARVALID&&AXI_ARREADY -> RD_RESP, deassert ARVALID, assert AXI_RREADY.
- RD_RESP: on AXI_RVALID&&AXI_RREADY, capture AXI_RDATA and AXI_RRESP, set rsp_write=0, deassert RREADY -> RESPOND.
- RESPOND: rsp_valid=1 with stable fields until rsp_ready; on handshake -> IDLE, rsp_valid=0, cmd_ready=1 next cycle.
- Minimum latency, zero-wait slave with rsp_ready held high:
  - cmd accept at cycle 0; VALID at cycle 1; handshake at cycle 1; BREADY/RREADY at cycle 2.
  - B/R at cycle 2 gives rsp_valid at cycle 3.
- AXI_BVALID or AXI_RVALID arriving in an unexpected state is ignored; no capture.
- Response codes pass through unmodified, including 2'b11 DECERR.
- Reset mid-transaction: asynchronously abandons the transaction and returns all outputs to reset values. Outstanding slave state is the system's concern.

Decomposition:
- Shared package axi4lite_pkg:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - master state enum;
  - data width 32 and strobe width 4 constants (also usable by the slave converter).
- Single module; no sub-module needed. The AW/W done-flag pair stays inline.

Test Plan:
- Write 0x0000_0010, data 0xDEAD_BEEF, wstrb 0xF; slave accepts AW and W same cycle, BRESP=00 -> AWADDR=0x10, WDATA=0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_resp=00, rsp_write=1.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after cycle 1, AWVALID held to cycle 4, BREADY only after both; single response.
- Read 0x0000_0004; slave returns RDATA=0x1234_5678, RRESP=00 after 2 wait cycles -> rsp_rdata=0x12345678, rsp_resp=00, ARVALID asserted for exactly one handshake.
- Read returning RRESP=2'b11 with rsp_ready held low 5 cycles -> rsp_valid and fields stable for 5 cycles; cmd_ready=0 throughout; IDLE after handshake.
- CHECK_ALIGN=1, write to 0x0000_0002 -> no AW/W/AR VALID ever; rsp_resp=2'b10 within 2 cycles.
- Assert rst_n=0 mid WR_REQ with AWVALID high -> AWVALID, WVALID, and rsp_valid go 0 immediately (asynchronous); cmd_ready=1 the first cycle after release.
